bundle_feeder: RTL and testbench

- Upstream sequencer for the bipolar element-addition-cut bundler; owns the accumulator's valid/first/last handshake.
- For each element index e, reads element e of NUM_HV stored FP32 hypervectors from source memory and streams them to the accumulator.
- After the last one, waits for the accumulator's done, then writes the clipped result to result memory at address e.
- Repeats for all HV_DIM elements, then signals completion.

---
 rtl/bundle_feeder.sv | 234 +++++++++++++++++++++++
 tb/tb_bundle_feeder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bundle_feeder.sv
// Purpose : sequences NUM_HV stored FP32 hypervectors, element by element, into the
//           bipolar add-and-cut accumulator and writes each clipped result to result memory.
// Latency : 3 cycles per operand (read, capture, issue) plus accumulator completion,
//           RESULT_DELAY settle cycles and one advance cycle per element.
// Backpressure: holds in S_ISSUE with the operand parked on acc_data while acc_ready is low.
//           No reads or strobes are issued while it waits.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   start / busy          run request (sampled only when idle) / not-idle indicator
//   done_all              one-cycle pulse that accompanies the return to idle after the last write
//   src_rden/addr/data    source memory read port; data returns one cycle after rden
//   acc_valid/first/last  operand strobe and framing to the accumulator
//   acc_data              operand, held from one capture until the next
//   acc_ready/done/result accumulator handshake and clipped output
//   dst_wren/addr/data    result memory write port, address = element index
//
// Every output is a flop. The combinational block computes next values for the
// state, the indices and the outputs, so strobes appear in the cycle after the
// decision that produces them.

module bundle_feeder #(
    parameter int HV_DATA_WIDTH = 32,
    parameter int HV_DIM        = 1024,
    parameter int NUM_HV        = 4,
    parameter int RESULT_DELAY  = 2,
    parameter int SRC_AW        = $clog2(NUM_HV * HV_DIM),
    parameter int DST_AW        = $clog2(HV_DIM)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done_all,
    output logic                     src_rden,
    output logic [SRC_AW-1:0]        src_addr,
    input  logic [HV_DATA_WIDTH-1:0] src_data,
    output logic                     acc_valid,
    output logic                     acc_first,
    output logic                     acc_last,
    output logic [HV_DATA_WIDTH-1:0] acc_data,
    input  logic                     acc_ready,
    input  logic                     acc_done,
    input  logic [HV_DATA_WIDTH-1:0] acc_result,
    output logic                     dst_wren,
    output logic [DST_AW-1:0]        dst_addr,
    output logic [HV_DATA_WIDTH-1:0] dst_data
);

    // The accumulator only reports done after a first and a last operand, so a
    // single-operand bundle would hang. A zero settle delay is not supported.
    // A one-element vector would leave the result address zero bits wide.
    generate
        if (NUM_HV < 2) begin : g_bad_num_hv
            $error("bundle_feeder: NUM_HV must be at least 2");
        end
        if (HV_DIM < 2) begin : g_bad_hv_dim
            $error("bundle_feeder: HV_DIM must be at least 2");
        end
        if (RESULT_DELAY < 1) begin : g_bad_result_delay
            $error("bundle_feeder: RESULT_DELAY must be at least 1");
        end
    endgenerate

    localparam int HW = (NUM_HV > 1) ? $clog2(NUM_HV) : 1;
    localparam int CW = (RESULT_DELAY > 1) ? $clog2(RESULT_DELAY) : 1;

    localparam logic [HW-1:0]     H_LAST = HW'(NUM_HV - 1);
    localparam logic [DST_AW-1:0] E_LAST = DST_AW'(HV_DIM - 1);
    localparam logic [CW-1:0]     C_LAST = CW'(RESULT_DELAY - 1);
    localparam logic [SRC_AW-1:0] DIM_S  = SRC_AW'(HV_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MEM,
        S_ISSUE,
        S_WAIT_DONE,
        S_SETTLE,
        S_NEXT
    } state_t;

    state_t              state, state_nxt;
    logic [DST_AW-1:0]   e, e_nxt;      // element index
    logic [HW-1:0]       h, h_nxt;      // hypervector index within the element
    logic [CW-1:0]       cnt, cnt_nxt;  // settle counter

    logic                     busy_nxt;
    logic                     done_all_nxt;
    logic                     src_rden_nxt;
    logic [SRC_AW-1:0]        src_addr_nxt;
    logic                     acc_valid_nxt;
    logic                     acc_first_nxt;
    logic                     acc_last_nxt;
    logic [HV_DATA_WIDTH-1:0] acc_data_nxt;
    logic                     dst_wren_nxt;
    logic [DST_AW-1:0]        dst_addr_nxt;
    logic [HV_DATA_WIDTH-1:0] dst_data_nxt;

    always_comb begin
        state_nxt     = state;
        e_nxt         = e;
        h_nxt         = h;
        cnt_nxt       = cnt;
        done_all_nxt  = 1'b0;
        acc_valid_nxt = 1'b0;
        acc_first_nxt = 1'b0;
        acc_last_nxt  = 1'b0;
        acc_data_nxt  = acc_data;
        dst_wren_nxt  = 1'b0;
        dst_addr_nxt  = dst_addr;
        dst_data_nxt  = dst_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    e_nxt     = '0;
                    h_nxt     = '0;
                    state_nxt = S_READ;
                end
            end

            // The read strobe is the registered image of being in S_READ,
            // so it lasts exactly this one cycle.
            S_READ: begin
                state_nxt = S_MEM;
            end

            // Source data is valid now, one cycle after the read strobe.
            S_MEM: begin
                acc_data_nxt = src_data;
                state_nxt    = S_ISSUE;
            end

            // The accumulator only moves ready on its own step or in response
            // to a strobe, so a sampled ready here is safe to act on.
            S_ISSUE: begin
                if (acc_ready) begin
                    acc_valid_nxt = 1'b1;
                    acc_first_nxt = (h == '0);
                    acc_last_nxt  = (h == H_LAST);
                    if (h != H_LAST) begin
                        h_nxt     = h + HW'(1);
                        state_nxt = S_READ;
                    end else begin
                        h_nxt     = '0;
                        state_nxt = S_WAIT_DONE;
                    end
                end
            end

            // Done is looked at only here. The accumulator also reports done
            // while it is idle, and that must never cause a write.
            S_WAIT_DONE: begin
                if (acc_done) begin
                    cnt_nxt   = '0;
                    state_nxt = S_SETTLE;
                end
            end

            // Give the accumulator's compare stage time to settle before
            // sampling the result.
            S_SETTLE: begin
                if (cnt == C_LAST) begin
                    dst_data_nxt = acc_result;
                    dst_addr_nxt = e;
                    dst_wren_nxt = 1'b1;
                    state_nxt    = S_NEXT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            S_NEXT: begin
                if (e == E_LAST) begin
                    done_all_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    e_nxt     = e + DST_AW'(1);
                    state_nxt = S_READ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The address is loaded only on entry to S_READ, using the indices
        // that S_READ itself will see. It holds otherwise.
        src_rden_nxt = (state_nxt == S_READ);
        src_addr_nxt = (state_nxt == S_READ)
                     ? (SRC_AW'(h_nxt) * DIM_S + SRC_AW'(e_nxt))
                     : src_addr;
        busy_nxt     = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            e         <= '0;
            h         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done_all  <= 1'b0;
            src_rden  <= 1'b0;
            src_addr  <= '0;
            acc_valid <= 1'b0;
            acc_first <= 1'b0;
            acc_last  <= 1'b0;
            acc_data  <= '0;
            dst_wren  <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= '0;
        end else begin
            state     <= state_nxt;
            e         <= e_nxt;
            h         <= h_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            done_all  <= done_all_nxt;
            src_rden  <= src_rden_nxt;
            src_addr  <= src_addr_nxt;
            acc_valid <= acc_valid_nxt;
            acc_first <= acc_first_nxt;
            acc_last  <= acc_last_nxt;
            acc_data  <= acc_data_nxt;
            dst_wren  <= dst_wren_nxt;
            dst_addr  <= dst_addr_nxt;
            dst_data  <= dst_data_nxt;
        end
    end

endmodule

// File: tb/tb_bundle_feeder.sv
// Purpose : directed bench for bundle_feeder with a source memory, a behavioural
//           add-and-clip accumulator and an event log. Checks are against hand-computed values.
// Latency : not applicable.
// Backpressure: the accumulator model can hold ready low and delay done on request.

module tb_bundle_feeder;

    localparam int W       = 32;
    localparam int DIM     = 4;
    localparam int NHV     = 3;
    localparam int RD      = 2;
    localparam int SAW     = 4;   // clog2(3*4)
    localparam int DAW     = 2;   // clog2(4)
    localparam int HOLDLEN = 10;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic           busy, done_all, src_rden;
    logic [SAW-1:0] src_addr;
    logic [W-1:0]   src_data = '0;
    logic           acc_valid, acc_first, acc_last;
    logic [W-1:0]   acc_data;
    logic           acc_ready, acc_done;
    logic [W-1:0]   acc_result;
    logic           dst_wren;
    logic [DAW-1:0] dst_addr;
    logic [W-1:0]   dst_data;

    always #5 clk = ~clk;

    bundle_feeder #(
        .HV_DATA_WIDTH(W), .HV_DIM(DIM), .NUM_HV(NHV), .RESULT_DELAY(RD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done_all(done_all),
        .src_rden(src_rden), .src_addr(src_addr), .src_data(src_data),
        .acc_valid(acc_valid), .acc_first(acc_first), .acc_last(acc_last), .acc_data(acc_data),
        .acc_ready(acc_ready), .acc_done(acc_done), .acc_result(acc_result),
        .dst_wren(dst_wren), .dst_addr(dst_addr), .dst_data(dst_data)
    );

    // ---------------- source memory: data one cycle after rden ----------------
    logic [W-1:0] mem [0:NHV*DIM-1];
    always @(posedge clk) if (src_rden) src_data <= mem[src_addr];

    // ---------------- FP32 helpers for the accumulator model ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  ex;
        if (b[30:0] == 31'd0) return 0.0;
        ex = int'(b[30:23]) - 127;
        m  = 1.0 + real'(b[22:0]) / 8388608.0;
        while (ex > 0) begin m = m * 2.0; ex--; end
        while (ex < 0) begin m = m / 2.0; ex++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  a;
        int   ex;
        int   mant;
        logic s;
        if (r == 0.0) return 32'd0;
        s  = (r < 0.0);
        a  = s ? -r : r;
        ex = 127;
        while (a >= 2.0) begin a = a / 2.0; ex++; end
        while (a < 1.0)  begin a = a * 2.0; ex--; end
        mant = int'((a - 1.0) * 8388608.0);
        return {s, 8'(ex), 23'(mant)};
    endfunction

    function automatic real clip(input real x);
        if (x > 1.0)  return 1.0;
        if (x < -1.0) return -1.0;
        return x;
    endfunction

    // ---------------- accumulator model ----------------
    // Reports done while idle, clears it on a first operand, and raises it
    // done_delay cycles after the last operand. With hold_req set, ready
    // drops for HOLDLEN cycles after each first operand.
    logic hold_req;
    int   done_delay;
    int   hcnt;
    int   dcnt;
    logic pend;
    real  acc_sum;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_ready  <= 1'b1;
            acc_done   <= 1'b1;
            acc_result <= '0;
            acc_sum    <= 0.0;
            pend       <= 1'b0;
            hcnt       <= 0;
            dcnt       <= 0;
        end else begin
            if (acc_valid) begin
                acc_sum <= acc_first ? f2r(acc_data) : acc_sum + f2r(acc_data);
                if (acc_first) acc_done <= 1'b0;
                if (acc_last) begin
                    pend <= 1'b1;
                    dcnt <= done_delay;
                end
            end
            if (pend && !(acc_valid && acc_last)) begin
                if (dcnt <= 1) begin
                    acc_done   <= 1'b1;
                    acc_result <= r2f(clip(acc_sum));
                    pend       <= 1'b0;
                end else begin
                    dcnt <= dcnt - 1;
                end
            end
            if (hold_req && acc_valid && acc_first) begin
                acc_ready <= 1'b0;
                hcnt      <= HOLDLEN - 1;
            end else if (!acc_ready) begin
                if (hcnt != 0) hcnt <= hcnt - 1;
                else           acc_ready <= 1'b1;
            end
        end
    end

    // ---------------- event log, sampled on the falling edge ----------------
    int          cyc = 0;
    int          last_v = -100;
    int          gap_viol = 0;
    int          stall_strobes = 0;
    logic        done_q = 1'b0;
    int          v_cyc[$];
    logic        v_first[$];
    logic        v_last[$];
    logic [31:0] v_dat[$];
    int          r_cyc[$];
    logic [31:0] r_addr[$];
    int          w_cyc[$];
    logic [31:0] w_addr[$];
    logic [31:0] w_dat[$];
    int          da_cyc[$];
    int          dr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        done_q <= acc_done;
        if (acc_done && !done_q) dr_cyc.push_back(cyc);
        if (acc_valid) begin
            if (cyc - last_v < 3) gap_viol <= gap_viol + 1;
            last_v <= cyc;
            v_cyc.push_back(cyc);
            v_first.push_back(acc_first);
            v_last.push_back(acc_last);
            v_dat.push_back(acc_data);
        end
        if (src_rden) begin
            r_cyc.push_back(cyc);
            r_addr.push_back(32'(src_addr));
        end
        if (dst_wren) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(32'(dst_addr));
            w_dat.push_back(dst_data);
        end
        if (done_all) da_cyc.push_back(cyc);
        if (!acc_ready && (src_rden || acc_valid)) stall_strobes <= stall_strobes + 1;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        v_cyc.delete(); v_first.delete(); v_last.delete(); v_dat.delete();
        r_cyc.delete(); r_addr.delete();
        w_cyc.delete(); w_addr.delete(); w_dat.delete();
        da_cyc.delete(); dr_cyc.delete();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        for (int e = 0; e < DIM; e++) begin
            mem[e]         = a;
            mem[DIM + e]   = b;
            mem[2*DIM + e] = c;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done_all(input int n, input int lim, input string tag);
        int i = 0;
        while (da_cyc.size() < n && i < lim) begin @(posedge clk); i++; end
        check(tag, 32'(int'(da_cyc.size() >= n)), 32'd1);
    endtask

    task automatic wait_writes(input int n, input int lim, input string tag);
        int i = 0;
        while (w_cyc.size() < n && i < lim) begin @(posedge clk); i++; end
        check(tag, 32'(int'(w_cyc.size() >= n)), 32'd1);
    endtask

    task automatic wait_reads(input int n, input int lim, input string tag);
        int i = 0;
        while (r_cyc.size() < n && i < lim) begin @(posedge clk); i++; end
        check(tag, 32'(int'(r_cyc.size() >= n)), 32'd1);
    endtask

    task automatic check_results(input string tag, input logic [31:0] exp);
        check({tag, "_nwr"}, 32'(w_cyc.size()), 32'd4);
        for (int i = 0; i < DIM; i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), w_addr[i], 32'(i));
            check($sformatf("%s_wr%0d_data", tag, i), w_dat[i], exp);
        end
        check({tag, "_ndone"}, 32'(da_cyc.size()), 32'd1);
    endtask

    task automatic run_case(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input string tag);
        load(a, b, c);
        @(posedge clk) clear_log();
        pulse_start();
        wait_done_all(1, 1500, {tag, "_timeout"});
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int nrd;
        reset_n    = 1'b0;
        start      = 1'b0;
        hold_req   = 1'b0;
        done_delay = 1;
        load(32'h3F000000, 32'h3E800000, 32'h3E000000);

        // Reset state. The accumulator model reports idle done=1 throughout.
        #12;
        check("rst_ctrl", 32'({busy, done_all, src_rden, acc_valid, acc_first, acc_last, dst_wren}), 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        check("rst_acc_data", acc_data, 32'd0);
        check("rst_dst_addr", 32'(dst_addr), 32'd0);
        check("rst_dst_data", dst_data, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk) clear_log();
        repeat (5) @(posedge clk);
        #1;
        check("idle_strobes", 32'(r_cyc.size() + v_cyc.size() + w_cyc.size() + da_cyc.size()), 32'd0);

        // Basic run: 0.5 + 0.25 + 0.125 = 0.875. Start pulses while busy are ignored.
        @(posedge clk) clear_log();
        pulse_start();
        repeat (15) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done_all(1, 1500, "basic_timeout");
        repeat (4) @(posedge clk);
        #1;
        check_results("basic", 32'h3F600000);
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_nrd", 32'(r_addr.size()), 32'd12);
        for (int k = 0; k < NHV*DIM; k++)
            check($sformatf("basic_rd%0d_addr", k), r_addr[k], 32'((k % NHV) * DIM + k / NHV));
        check("basic_v0_flags", 32'({v_first[0], v_last[0]}), 32'b10);
        check("basic_v1_flags", 32'({v_first[1], v_last[1]}), 32'b00);
        check("basic_v2_flags", 32'({v_first[2], v_last[2]}), 32'b01);
        check("basic_v0_data", v_dat[0], 32'h3F000000);
        check("basic_v1_data", v_dat[1], 32'h3E800000);
        check("basic_v2_data", v_dat[2], 32'h3E000000);

        // Clipping: 1+1+0.5 -> +1.0 and -1-1-0.5 -> -1.0
        run_case(32'h3F800000, 32'h3F800000, 32'h3F000000, "clip_pos");
        check_results("clip_pos", 32'h3F800000);
        run_case(32'hBF800000, 32'hBF800000, 32'hBF000000, "clip_neg");
        check_results("clip_neg", 32'hBF800000);

        // Ready held low for HOLDLEN cycles after each first operand; done delayed by 20 cycles
        hold_req   = 1'b1;
        done_delay = 20;
        run_case(32'h3F000000, 32'h3E800000, 32'h3E000000, "hs");
        hold_req   = 1'b0;
        done_delay = 1;
        check("hs_v1_gap", 32'(v_cyc[1] - v_cyc[0]), 32'(HOLDLEN + 2));
        check("hs_stall_strobes", 32'(stall_strobes), 32'd0);
        check("hs_v1_flags", 32'({v_first[1], v_last[1]}), 32'b00);
        check("hs_v2_flags", 32'({v_first[2], v_last[2]}), 32'b01);
        nrd = 0;
        foreach (r_cyc[k]) if (r_cyc[k] < w_cyc[0]) nrd++;
        check("hs_reads_elem0", 32'(nrd), 32'd3);
        check("hs_done_to_wr", 32'(w_cyc[0] - dr_cyc[0]), 32'(RD + 1));
        check("hs_wr0_data", w_dat[0], 32'h3F600000);

        // Abort after two results, then restart with start held through done_all
        load(32'h3F000000, 32'h3E800000, 32'h3E000000);
        @(posedge clk) clear_log();
        pulse_start();
        wait_writes(2, 1500, "abort_wait2");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ctrl", 32'({busy, done_all, src_rden, acc_valid, acc_first, acc_last, dst_wren}), 32'd0);
        check("abort_src_addr", 32'(src_addr), 32'd0);
        check("abort_acc_data", acc_data, 32'd0);
        check("abort_dst_addr", 32'(dst_addr), 32'd0);
        check("abort_dst_data", dst_data, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk) clear_log();
        repeat (5) @(posedge clk);
        #1;
        check("abort_idle_strobes", 32'(r_cyc.size() + v_cyc.size() + w_cyc.size() + da_cyc.size()), 32'd0);
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_write", 32'(w_cyc.size()), 32'd0);

        @(negedge clk) start = 1'b1;
        wait_reads(1, 50, "restart_rd_timeout");
        check("restart_rd0_addr", r_addr[0], 32'd0);
        wait_writes(1, 1500, "restart_wr_timeout");
        check("restart_wr0_addr", w_addr[0], 32'd0);
        wait_done_all(1, 1500, "restart_done_timeout");
        wait_reads(13, 50, "rerun_rd_timeout");
        @(negedge clk) start = 1'b0;
        check("rerun_start_lat", 32'(r_cyc[12] - da_cyc[0]), 32'd1);
        check("rerun_rd_addr", r_addr[12], 32'd0);
        wait_done_all(2, 1500, "rerun_done_timeout");

        check("valid_gap_viol", 32'(gap_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
